// File: rtl/pipe_stage_reg_pkg.sv
// Shared constants for the pipeline boundary register and the stages that
// pack their channels into it.
package pipe_stage_reg_pkg;

  // Occupancy states; the encoding doubles as the level output.
  localparam logic [1:0] ST_EMPTY = 2'd0;
  localparam logic [1:0] ST_ONE   = 2'd1;
  localparam logic [1:0] ST_TWO   = 2'd2;

  // Default channel slots used by the D/E, E/M and M/W boundaries.
  localparam int unsigned CH_IR  = 0;
  localparam int unsigned CH_PC4 = 1;
  localparam int unsigned CH_EXT = 2;
  localparam int unsigned CH_RD1 = 3;
  localparam int unsigned CH_RD2 = 4;

endpackage

// File: rtl/pipe_stage_reg_sat_counter.sv
// Saturating up-counter for performance debug; sticks at all-ones.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
  output logic [W-1:0] count
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  // Advance on inc unless already at the maximum value.
  always_comb begin
    count_d = count_q;
    if (inc && (count_q != {W{1'b1}})) begin
      count_d = count_q + 1'b1;
    end
  end

  // Counter register, cleared only by reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// Pipeline boundary register with valid/ready handshake and a 2-entry skid
// buffer, so in_ready comes straight from a flop. Supports flush (bubble
// insertion), an occupancy output and a saturating stall counter.
module pipe_stage_reg
  import pipe_stage_reg_pkg::*;
#(
  parameter int DATA_W       = 32,
  parameter int N_CH         = 5,
  parameter bit CLR_ON_EMPTY = 1'b1,
  parameter int CNT_W        = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [N_CH*DATA_W-1:0] in_data,
  input  logic                   flush,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [N_CH*DATA_W-1:0] out_data,
  output logic [1:0]             level,
  output logic [CNT_W-1:0]       stall_cnt
);

  localparam int BUS_W = N_CH * DATA_W;

  logic [1:0]       state_q, state_d;
  logic [BUS_W-1:0] main_q, main_d;
  logic [BUS_W-1:0] skid_q, skid_d;
  logic             in_ready_q, in_ready_d;
  logic             in_fire, out_fire;

  assign out_valid = (state_q != ST_EMPTY);
  assign in_fire   = in_valid && in_ready_q;
  assign out_fire  = out_valid && out_ready;

  // Next-state and data movement; flush overrides every transition and
  // drops any word offered in the same cycle.
  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    if (flush) begin
      state_d = ST_EMPTY;
      if (CLR_ON_EMPTY) begin
        main_d = '0;
        skid_d = '0;
      end
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (in_fire) begin
            main_d  = in_data;
            state_d = ST_ONE;
          end
        end
        ST_ONE: begin
          if (in_fire && out_fire) begin
            main_d = in_data;
          end else if (in_fire) begin
            skid_d  = in_data;
            state_d = ST_TWO;
          end else if (out_fire) begin
            state_d = ST_EMPTY;
            if (CLR_ON_EMPTY) begin
              main_d = '0;
            end
          end
        end
        ST_TWO: begin
          if (out_fire) begin
            main_d  = skid_q;
            state_d = ST_ONE;
            if (CLR_ON_EMPTY) begin
              skid_d = '0;
            end
          end
        end
        default: begin
          state_d = ST_EMPTY;
          main_d  = '0;
          skid_d  = '0;
        end
      endcase
    end
    in_ready_d = (state_d != ST_TWO);
  end

  // State, data and registered ready flops.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_EMPTY;
      main_q     <= '0;
      skid_q     <= '0;
      in_ready_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      main_q     <= main_d;
      skid_q     <= skid_d;
      in_ready_q <= in_ready_d;
    end
  end

  assign in_ready = in_ready_q;
  assign out_data = main_q;
  assign level    = state_q;

  sat_counter #(
    .W(CNT_W)
  ) u_stall_cnt (
    .clk  (clk),
    .reset(reset),
    .inc  (out_valid && !out_ready),
    .count(stall_cnt)
  );

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed, table-driven bench for pipe_stage_reg with hand-written
// sequences for reset, counter saturation and asynchronous reset.
module tb_pipe_stage_reg;
  import pipe_stage_reg_pkg::*;

  localparam int DW = 32;
  localparam int NC = 5;
  localparam int CW = 4;

  logic            clk = 1'b0;
  logic            reset;
  logic            in_valid;
  logic            in_ready;
  logic [NC*DW-1:0] in_data;
  logic            flush;
  logic            out_valid;
  logic            out_ready;
  logic [NC*DW-1:0] out_data;
  logic [1:0]      level;
  logic [CW-1:0]   stall_cnt;

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    logic        iv;
    logic [31:0] v;
    logic        fl;
    logic        ordy;
    logic        eov;
    logic        eir;
    logic [1:0]  elvl;
    logic [31:0] ev;
    logic [3:0]  estall;
  } vec_t;

  vec_t vecs[26];

  pipe_stage_reg #(
    .DATA_W(DW),
    .N_CH(NC),
    .CLR_ON_EMPTY(1'b1),
    .CNT_W(CW)
  ) dut (
    .clk(clk),
    .reset(reset),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_data(in_data),
    .flush(flush),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data(out_data),
    .level(level),
    .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  // Spread a value over all channels; zero stays an all-zero bus.
  function automatic logic [NC*DW-1:0] build(input logic [31:0] v);
    logic [NC*DW-1:0] d;
    d = '0;
    if (v != 32'd0) begin
      d[CH_IR*DW  +: DW] = v;
      d[CH_PC4*DW +: DW] = v + 32'h0000_0004;
      d[CH_EXT*DW +: DW] = ~v;
      d[CH_RD1*DW +: DW] = {v[15:0], v[31:16]};
      d[CH_RD2*DW +: DW] = v ^ 32'hA5A5_0000;
    end
    return d;
  endfunction

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic iv, input logic [31:0] v,
                               input logic fl, input logic ordy);
    in_valid  = iv;
    in_data   = build(v);
    flush     = fl;
    out_ready = ordy;
  endtask

  task automatic checkOutput(input string name, input logic eov, input logic eir,
                             input logic [1:0] elvl, input logic [NC*DW-1:0] edata,
                             input logic [CW-1:0] estall);
    n_vec++;
    if (out_valid !== eov || in_ready !== eir || level !== elvl ||
        out_data !== edata || stall_cnt !== estall) begin
      n_err++;
      $display("[TB] FAIL %s: got ov=%b ir=%b lvl=%0d data=%h stall=%0d, want ov=%b ir=%b lvl=%0d data=%h stall=%0d",
               name, out_valid, in_ready, level, out_data, stall_cnt,
               eov, eir, elvl, edata, estall);
    end
  endtask

  initial begin
    int exp_stall;

    // Streaming 1..8 with out_ready held high.
    for (int i = 0; i < 8; i++) begin
      vecs[i] = '{1'b1, 32'(i + 1), 1'b0, 1'b1, 1'b1, 1'b1, ST_ONE, 32'(i + 1), 4'd0};
    end
    vecs[8]  = '{1'b0, 32'h00, 1'b0, 1'b1, 1'b0, 1'b1, ST_EMPTY, 32'h00, 4'd0};
    // Backpressure into the skid, then drain.
    vecs[9]  = '{1'b1, 32'h11, 1'b0, 1'b0, 1'b1, 1'b1, ST_ONE,   32'h11, 4'd0};
    vecs[10] = '{1'b1, 32'h22, 1'b0, 1'b0, 1'b1, 1'b0, ST_TWO,   32'h11, 4'd1};
    vecs[11] = '{1'b0, 32'h00, 1'b0, 1'b0, 1'b1, 1'b0, ST_TWO,   32'h11, 4'd2};
    vecs[12] = '{1'b1, 32'h99, 1'b0, 1'b1, 1'b1, 1'b1, ST_ONE,   32'h22, 4'd2};
    vecs[13] = '{1'b0, 32'h00, 1'b0, 1'b1, 1'b0, 1'b1, ST_EMPTY, 32'h00, 4'd2};
    // Flush while two entries are held and C is offered.
    vecs[14] = '{1'b1, 32'h11, 1'b0, 1'b0, 1'b1, 1'b1, ST_ONE,   32'h11, 4'd2};
    vecs[15] = '{1'b1, 32'h22, 1'b0, 1'b0, 1'b1, 1'b0, ST_TWO,   32'h11, 4'd3};
    vecs[16] = '{1'b1, 32'h33, 1'b1, 1'b0, 1'b0, 1'b1, ST_EMPTY, 32'h00, 4'd4};
    vecs[17] = '{1'b0, 32'h00, 1'b0, 1'b1, 1'b0, 1'b1, ST_EMPTY, 32'h00, 4'd4};
    // Flush with a simultaneous out_fire and a dropped in_fire.
    vecs[18] = '{1'b1, 32'h44, 1'b0, 1'b1, 1'b1, 1'b1, ST_ONE,   32'h44, 4'd4};
    vecs[19] = '{1'b1, 32'h55, 1'b1, 1'b1, 1'b0, 1'b1, ST_EMPTY, 32'h00, 4'd4};
    vecs[20] = '{1'b0, 32'h00, 1'b0, 1'b1, 1'b0, 1'b1, ST_EMPTY, 32'h00, 4'd4};
    // Flush from empty with a word offered.
    vecs[21] = '{1'b1, 32'h66, 1'b1, 1'b1, 1'b0, 1'b1, ST_EMPTY, 32'h00, 4'd4};
    vecs[22] = '{1'b0, 32'h00, 1'b0, 1'b1, 1'b0, 1'b1, ST_EMPTY, 32'h00, 4'd4};
    // Flush from one entry while a word would go to the skid.
    vecs[23] = '{1'b1, 32'h77, 1'b0, 1'b0, 1'b1, 1'b1, ST_ONE,   32'h77, 4'd4};
    vecs[24] = '{1'b1, 32'h88, 1'b1, 1'b0, 1'b0, 1'b1, ST_EMPTY, 32'h00, 4'd5};
    vecs[25] = '{1'b0, 32'h00, 1'b0, 1'b0, 1'b0, 1'b1, ST_EMPTY, 32'h00, 4'd5};

    // Reset held with an all-ones word offered.
    reset     = 1'b0;
    in_valid  = 1'b1;
    in_data   = '1;
    flush     = 1'b0;
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cycle();
      checkOutput($sformatf("reset%0d", i), 1'b0, 1'b1, ST_EMPTY, '0, 4'd0);
    end
    reset = 1'b1;
    cycle();
    checkOutput("rst_release", 1'b1, 1'b1, ST_ONE, '1, 4'd0);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b1);
    cycle();
    checkOutput("rst_drain", 1'b0, 1'b1, ST_EMPTY, '0, 4'd0);

    for (int i = 0; i < 26; i++) begin
      applyStimulus(vecs[i].iv, vecs[i].v, vecs[i].fl, vecs[i].ordy);
      cycle();
      checkOutput($sformatf("vec%0d", i), vecs[i].eov, vecs[i].eir, vecs[i].elvl,
                  build(vecs[i].ev), vecs[i].estall);
    end

    // Stall counter saturation, starting from a count of 5.
    applyStimulus(1'b1, 32'h99, 1'b0, 1'b0);
    cycle();
    checkOutput("sat_load", 1'b1, 1'b1, ST_ONE, build(32'h99), 4'd5);
    exp_stall = 5;
    for (int i = 1; i <= 20; i++) begin
      applyStimulus(1'b0, 32'h0, 1'b0, 1'b0);
      cycle();
      if (exp_stall < 15) exp_stall++;
      checkOutput($sformatf("sat%0d", i), 1'b1, 1'b1, ST_ONE, build(32'h99), CW'(exp_stall));
    end
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);
    cycle();
    checkOutput("sat_flush", 1'b0, 1'b1, ST_EMPTY, '0, 4'd15);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0);
    cycle();
    checkOutput("sat_idle", 1'b0, 1'b1, ST_EMPTY, '0, 4'd15);

    // Asynchronous reset in the middle of a cycle, then normal restart.
    applyStimulus(1'b1, 32'hAA, 1'b0, 1'b0);
    cycle();
    checkOutput("arst_load", 1'b1, 1'b1, ST_ONE, build(32'hAA), 4'd15);
    #2;
    reset = 1'b0;
    #1;
    checkOutput("arst_async", 1'b0, 1'b1, ST_EMPTY, '0, 4'd0);
    @(negedge clk);
    reset = 1'b1;
    applyStimulus(1'b1, 32'hBB, 1'b0, 1'b1);
    cycle();
    checkOutput("arst_first", 1'b1, 1'b1, ST_ONE, build(32'hBB), 4'd0);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b1);
    cycle();
    checkOutput("arst_drain", 1'b0, 1'b1, ST_EMPTY, '0, 4'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
